// File: rtl/ram_nb_8w.sv
// Eight-word line store for the I-cache data array.
// Combinational read gated by OE, synchronous write under active-low WR.

module ram_nb_8w_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] a,
  input  logic [7:0] din,
  input  logic       oe,
  input  logic [7:0] we,
  output logic [7:0] dout
);

  logic [7:0] mem [0:7];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rst)
        mem[i] <= 8'h00;
      else if (we[i])
        mem[i] <= din;
    end
  end

  assign dout = oe ? mem[a] : 8'h00;

endmodule

module ram_nb_8w #(
  parameter int NBYTES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            A,
  input  logic [8*NBYTES-1:0]   DIN,
  input  logic                  OE,
  input  logic                  WR,
  output logic [8*NBYTES-1:0]   DOUT
);

  logic [7:0] we;

  // Word enables resolve to 0 whenever WR is high, so an unknown A
  // during a read cannot reach the storage.
  always_comb begin
    we = 8'h00;
    for (int i = 0; i < 8; i++)
      we[i] = !WR && (A == 3'(i));
  end

  for (genvar k = 0; k < NBYTES; k++) begin : g_lane
    ram_nb_8w_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .a    (A),
      .din  (DIN[8*k +: 8]),
      .oe   (OE),
      .we   (we),
      .dout (DOUT[8*k +: 8])
    );
  end

endmodule

// File: tb/tb_ram_nb_8w.sv
// Bench for ram_nb_8w: directed vector table, OE corner sequence,
// and randomized traffic against an array reference model.

module tb_ram_nb_8w;

  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   A;
  logic [W-1:0] DIN;
  logic         OE;
  logic         WR;
  logic [W-1:0] DOUT;

  int vectors = 0;
  int miscompares = 0;

  ram_nb_8w #(.NBYTES(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .DIN  (DIN),
    .OE   (OE),
    .WR   (WR),
    .DOUT (DOUT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [2:0]   a;
    logic         oe;
    logic         wr;
    logic [W-1:0] din;
    logic         chk;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [W-1:0] rep(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [W-1:0] pat(input int a);
    logic [2:0] a3;
    a3 = 3'(a);
    return rep({a3, 5'h1F});
  endfunction

  function automatic vec_t mk(input logic r, input int a, input logic oe,
                              input logic wr, input logic [W-1:0] din,
                              input logic chk, input logic [W-1:0] exp,
                              input string name);
    vec_t v;
    v.rst = r; v.a = 3'(a); v.oe = oe; v.wr = wr;
    v.din = din; v.chk = chk; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic compare(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; A = v.a; OE = v.oe; WR = v.wr; DIN = v.din;
    #1;
    if (v.chk) compare(v.name, DOUT, v.exp);
  endtask

  logic [W-1:0] ones;
  logic [W-1:0] db;
  logic [W-1:0] ref_mem [8];

  initial begin
    ones = '1;
    db = {8{32'hDEADBEEF}};
    rst = 1'b1; A = '0; OE = 1'b1; WR = 1'b1; DIN = '0;

    // reset with a write presented, then sweep
    vecs.push_back(mk(1, 3, 1, 0, ones, 0, '0, "rst_edge"));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, i, 1, 1, '0, 1, '0, "rst_sweep"));
    // write all words; pre-edge read shows old (zero) contents
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, i, 1, 0, pat(i), 1, '0, "wr_all_old"));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, i, 1, 1, '0, 1, pat(i), "rd_all"));
    // strobe polarity and hold
    vecs.push_back(mk(0, 5, 1, 0, db, 1, pat(5), "wr5_old"));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 5, 1, 1, '0, 1, db, "hold5"));
    // word 4 written with OE low
    vecs.push_back(mk(0, 4, 0, 0, rep(8'h3C), 1, '0, "wr4_oe0"));
    vecs.push_back(mk(0, 4, 1, 1, '0, 1, rep(8'h3C), "rd4_oe1"));
    // read during write and back-to-back overwrite
    vecs.push_back(mk(0, 6, 1, 0, rep(8'h11), 1, pat(6), "rdw6_a"));
    vecs.push_back(mk(0, 6, 1, 0, rep(8'h22), 1, rep(8'h11), "rdw6_b"));
    vecs.push_back(mk(0, 6, 1, 1, '0, 1, rep(8'h22), "ovr6"));
    // reset priority over a write on the same edge
    vecs.push_back(mk(0, 1, 1, 0, ones, 1, pat(1), "wr1_ones"));
    vecs.push_back(mk(1, 1, 1, 0, rep(8'h55), 1, ones, "rst_prio"));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, i, 1, 1, '0, 1, '0, "prio_sweep"));

    foreach (vecs[i]) apply(vecs[i]);

    // OE toggles with no clock edge in between
    apply(mk(0, 2, 1, 0, rep(8'hA5), 0, '0, "wr2"));
    @(negedge clk);
    rst = 0; A = 3'd2; WR = 1'b1; DIN = '0; OE = 1'b0;
    #1 compare("oe_off", DOUT, '0);
    OE = 1'b1;
    #1 compare("oe_on", DOUT, rep(8'hA5));

    // randomized traffic against the array model
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    ref_mem[2] = rep(8'hA5);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 19) == 0);
      A = 3'($urandom_range(0, 7));
      OE = ($urandom_range(0, 4) != 0);
      WR = $urandom_range(0, 1) == 1;
      for (int j = 0; j < 8; j++) DIN[32*j +: 32] = $urandom;
      #1 compare("rand", DOUT, OE ? ref_mem[A] : '0);
      @(posedge clk);
      if (rst)
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;
      else if (!WR)
        ref_mem[A] = DIN;
    end

    // final readback of every word
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst = 0; WR = 1; OE = 1; A = 3'(i);
      #1 compare("final_rd", DOUT, ref_mem[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_nb_8w.md
# ram_nb_8w

Eight-word, N-byte-wide RAM used as the line storage array of the instruction cache data store. Two instances back the 16-line, 32-byte-line cache; bit 3 of the cache index selects which instance the cache uses. Each instance holds one full cache line per word. Reads are combinational. Writes are committed synchronously on the clock edge under an active-low write strobe, so a cache fill can be written in one cycle and the line read back in the next.

## Interface
Parameters:
- NBYTES, default 32: word width in bytes; the data width is 8*NBYTES bits (256 by default).

Ports (clock and reset first):
- clk, input, 1: single clock. All state changes happen on its rising edge.
- rst, input, 1: reset, synchronous and active-high. Clears every word.
- A, input, 3: word address, selecting one of words 0..7.
- DIN, input, 8*NBYTES: write data.
- OE, input, 1: output enable, active-high.
- WR, input, 1: write strobe, active-low.
- DOUT, output, 8*NBYTES: read data.

## Operation
- Storage is 8 words of 8*NBYTES bits.
  - Implement as NBYTES byte lanes, each an 8-word by 8-bit bank sharing A, WR and OE.
  - Lane k holds bits [8k+7:8k].
- Read:
  - DOUT = mem[A] when OE=1.
  - DOUT = all zeros when OE=0. Outputs are never tri-stated.
- Write: at a rising clk edge with rst=0 and WR=0, mem[A] <= DIN. No other word changes.
- Hold: at a rising clk edge with rst=0 and WR=1, all words are unchanged.
- Reset:
  - At a rising clk edge with rst=1, all 8 words are cleared to 0, whatever WR, A and DIN are. Reset has priority over write.
  - After reset with OE=1, DOUT = 0 for every A.
- There are no byte enables. A write always updates the full word.
- The OE value does not affect writes.
- A, DIN, OE and WR are all unregistered inputs. X or Z on A while WR=1 must not corrupt storage.

## Timing
- Read latency is zero cycles: DOUT follows A and OE combinationally.
- Write latency is one edge: new data appears on DOUT immediately after the rising edge that captures the write, provided A still points to that word.
- Read during write, same address: before the edge DOUT shows the old contents. There is no write-through bypass.
- Consecutive writes on back-to-back edges to the same or different addresses are all committed in order. Where the same word is written twice, the last write wins.
- Reset mid-operation: an edge with rst=1 discards any write presented on that edge. Writes resume on the first edge with rst=0.
- The outputs have no reset value of their own. DOUT reflects array contents gated by OE, so it reads 0 after reset with OE=1.

## Test plan
- Reset: assert rst for 1 edge with WR=0, A=3 and DIN=all-ones. Then sweep A from 0 to 7 with OE=1. Required: DOUT=0 for every address.
- Write/read all words:
  - Write DIN = {32{A,5'h1F}} to each A from 0 to 7 on consecutive edges.
  - Then read each A combinationally with WR=1.
  - Required: each DOUT equals its written pattern, and no neighbouring word is disturbed.
- Write strobe polarity and hold:
  - Write A=5 with 256'hDEADBEEF repeated.
  - Then hold WR=1 for 4 edges with DIN=0 and A=5.
  - Required: DOUT stays 256'hDEADBEEF repeated.
- Output enable:
  - With word 2 = 256'hA5 repeated, set OE=0. Required: DOUT=0.
  - Then set OE=1. Required: the pattern returns with no clock edge.
  - Also write word 4 with OE=0, then read it with OE=1. Required: the new data is present.
- Read during write and overwrite:
  - Hold A=6 with WR=0. Required: DOUT shows the old value before the edge and the new value after it.
  - Write word 6 twice on back-to-back edges (0x11.. then 0x22..). Required: DOUT=0x22.. repeated.
- Reset priority: with word 1 = all-ones, present rst=1, WR=0, A=1 and DIN=0x55.. on one edge. Required: word 1 = 0 and every other word = 0.
